prog_clk_divider: RTL and testbench

- Runtime-programmable clock divider with enable.
- Generates a near-50%-duty divided clock (Clk_Out) and a one-cycle tick strobe (Tick_Out) per output period, both from Clk_In.
- The divisor is loaded through a shadow register and applied only at period boundaries, so the output never glitches.
- Drives the traffic-light sequencers and any other slow-time-base logic; replaces fixed-ratio dividers.

---
 rtl/prog_clk_divider.sv | 136 +++++++++++++
 tb/tb_prog_clk_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: runtime-programmable clock divider with enable.
// Clk_Out is a near-50% divided clock and Tick_Out a one-cycle strobe
// per period; both registered. Divisor loads go through a shadow
// register and take effect only at a period boundary.
// Ports: Clk_In, Rst (sync, active-high), En, Div_Value, Div_Load in;
//   Clk_Out, Tick_Out, Div_Active, Div_Pend, Div_Err out.
// Optional: define CLKDIV_PHASE_OUT_EN to add Phase_Out (= phase count).
module prog_clk_divider #(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 100000000
) (
  input  logic             Clk_In,
  input  logic             Rst,
  input  logic             En,
  input  logic [CNT_W-1:0] Div_Value,
  input  logic             Div_Load,
  output logic             Clk_Out,
  output logic             Tick_Out,
  output logic [CNT_W-1:0] Div_Active,
  output logic             Div_Pend,
`ifdef CLKDIV_PHASE_OUT_EN
  output logic [CNT_W-1:0] Phase_Out,
`endif
  output logic             Div_Err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] active, active_n;
  logic [CNT_W-1:0] shadow, shadow_n;
  logic             pend, pend_n;
  logic             clk_q, clk_n;
  logic             tick_q, tick_n;
  logic             err_q, err_n;

  logic             ld_err;
  logic             ld_ok;
  logic             wrap;
  logic [CNT_W-1:0] n_cur;
  logic [CNT_W-1:0] n_lo;
  logic [CNT_W-1:0] nxt;

  always_comb begin
    state_n  = En ? RUN : IDLE;
    cnt_n    = cnt;
    active_n = active;
    shadow_n = shadow;
    pend_n   = pend;
    clk_n    = clk_q;
    tick_n   = tick_q;

    ld_err = Div_Load && (Div_Value < TWO);
    ld_ok  = Div_Load && !ld_err;
    err_n  = ld_err;

    // A load while idle is applied immediately, so it also sets the
    // divisor used by the first counting edge.
    n_cur = (state == IDLE && ld_ok) ? Div_Value : active;
    n_lo  = n_cur - (n_cur >> 1);
    wrap  = (cnt == n_cur - ONE);
    nxt   = wrap ? '0 : cnt + ONE;

    if (!En) begin
      cnt_n  = '0;
      clk_n  = 1'b0;
      tick_n = 1'b0;
      pend_n = 1'b0;
      if (ld_ok)
        active_n = Div_Value;
      else if (pend)
        active_n = shadow;
    end else begin
      cnt_n  = nxt;
      clk_n  = (nxt >= n_lo);
      tick_n = (nxt == n_cur - ONE);
      case (state)
        IDLE: begin
          if (ld_ok)
            active_n = Div_Value;
        end
        RUN: begin
          // Pending value goes live on the wrap; a load on the same
          // edge becomes the next pending value.
          if (wrap) begin
            pend_n = 1'b0;
            if (pend)
              active_n = shadow;
          end
          if (ld_ok) begin
            shadow_n = Div_Value;
            pend_n   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Rst) begin
      state  <= IDLE;
      cnt    <= '0;
      active <= DEF;
      shadow <= '0;
      pend   <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      active <= active_n;
      shadow <= shadow_n;
      pend   <= pend_n;
      clk_q  <= clk_n;
      tick_q <= tick_n;
      err_q  <= err_n;
    end
  end

  assign Clk_Out    = clk_q;
  assign Tick_Out   = tick_q;
  assign Div_Active = active;
  assign Div_Pend   = pend;
  assign Div_Err    = err_q;
`ifdef CLKDIV_PHASE_OUT_EN
  assign Phase_Out  = cnt;
`endif

endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: directed bench for prog_clk_divider.
// DEFAULT_DIV=10, CNT_W=8.
module tb_prog_clk_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] div_value;
  logic         div_load;
  logic         clk_out;
  logic         tick_out;
  logic [W-1:0] div_active;
  logic         div_pend;
  logic         div_err;
`ifdef CLKDIV_PHASE_OUT_EN
  logic [W-1:0] phase;
`endif

  int checks   = 0;
  int failures = 0;
  int n, lo, hi;

  always #5 clk = ~clk;

  prog_clk_divider #(.CNT_W(W), .DEFAULT_DIV(10)) dut (
    .Clk_In    (clk),
    .Rst       (rst),
    .En        (en),
    .Div_Value (div_value),
    .Div_Load  (div_load),
    .Clk_Out   (clk_out),
    .Tick_Out  (tick_out),
    .Div_Active(div_active),
    .Div_Pend  (div_pend),
`ifdef CLKDIV_PHASE_OUT_EN
    .Phase_Out (phase),
`endif
    .Div_Err   (div_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until Tick_Out is seen high (bounded).
  task automatic wait_tick(output int e);
    e = 0;
    do begin
      step();
      e++;
    end while (!tick_out && e < 100);
  endtask

  // From a tick sample: period length and Clk_Out low/high counts.
  task automatic measure(output int p, output int l, output int h);
    p = 0; l = 0; h = 0;
    do begin
      step();
      p++;
      if (clk_out) h++;
      else l++;
    end while (!tick_out && p < 100);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_value = '0; div_load = 1'b0;
    step();
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick_out, 0);
    chk("rst_active", div_active, 10);
    chk("rst_pend", div_pend, 0);
    chk("rst_err", div_err, 0);
`ifdef CLKDIV_PHASE_OUT_EN
    chk("rst_phase", phase, 0);
`endif

    // N=10 from reset
    rst = 1'b0; en = 1'b1;
    wait_tick(n);
    chk("first_tick10", n, 9);
    measure(n, lo, hi);
    chk("per10", n, 10);
    chk("lo10", lo, 5);
    chk("hi10", hi, 5);

    // Load 5 in IDLE
    en = 1'b0;
    step();
    chk("idle_clk", clk_out, 0);
    chk("idle_tick", tick_out, 0);
    div_load = 1'b1; div_value = 5;
    step();
    div_load = 1'b0;
    chk("idle_ld_active", div_active, 5);
    chk("idle_ld_pend", div_pend, 0);
    en = 1'b1;
    wait_tick(n);
    chk("first_tick5", n, 4);
    measure(n, lo, hi);
    chk("per5", n, 5);
    chk("lo5", lo, 3);
    chk("hi5", hi, 2);

    // N=10, load 4 at cnt=3
    en = 1'b0;
    step();
    div_load = 1'b1; div_value = 10;
    step();
    div_load = 1'b0;
    chk("reload10", div_active, 10);
    en = 1'b1;
    step(3);
    div_load = 1'b1; div_value = 4;
    step();
    div_load = 1'b0;
    chk("run_ld_pend", div_pend, 1);
    chk("run_ld_active", div_active, 10);
    wait_tick(n);
    chk("old_period_rest", n, 5);
    chk("pend_at_tick", div_pend, 1);
    measure(n, lo, hi);
    chk("per4", n, 4);
    chk("lo4", lo, 2);
    chk("hi4", hi, 2);
    chk("active4", div_active, 4);
    chk("pend_clr", div_pend, 0);

    // Rejected loads (tick sample, cnt=3)
    div_load = 1'b1; div_value = 1;
    step();
    chk("err_v1", div_err, 1);
    div_value = 0;
    step();
    chk("err_v0", div_err, 1);
    div_load = 1'b0;
    step();
    chk("err_clr", div_err, 0);
    chk("err_active", div_active, 4);
    chk("err_pend", div_pend, 0);
    wait_tick(n);
    chk("err_phase", n, 1);

    // Load 6 then 8 in one period (tick sample, cnt=3)
    step();
    div_load = 1'b1; div_value = 6;
    step();
    div_load = 1'b0;
    chk("ld6_pend", div_pend, 1);
    step();
    div_load = 1'b1; div_value = 8;
    step();
    div_load = 1'b0;
    wait_tick(n);
    chk("to_tick8", n, 8);
    chk("active8", div_active, 8);
    chk("pend8", div_pend, 0);
    measure(n, lo, hi);
    chk("per8", n, 8);
    chk("lo8", lo, 4);
    chk("hi8", hi, 4);

    // Reset mid-period with a pending load (tick sample, cnt=7)
    step(2);
    div_load = 1'b1; div_value = 3;
    step();
    div_load = 1'b0;
    chk("pre_rst_pend", div_pend, 1);
    step(2);
    chk("pre_rst_clk", clk_out, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_clk", clk_out, 0);
    chk("mid_rst_tick", tick_out, 0);
    chk("mid_rst_pend", div_pend, 0);
    chk("mid_rst_active", div_active, 10);
    chk("mid_rst_err", div_err, 0);
    rst = 1'b0;
    wait_tick(n);
    chk("post_rst_tick", n, 9);

    // En falls with a pending load (tick sample, cnt=9)
    step(2);
    div_load = 1'b1; div_value = 6;
    step();
    div_load = 1'b0;
    chk("fall_pend", div_pend, 1);
    en = 1'b0;
    step();
    chk("fall_active", div_active, 6);
    chk("fall_pend_clr", div_pend, 0);
    chk("fall_clk", clk_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
